// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/reset sequencer: pushes PC and P, fetches vectors, pulls state back on RTI,
// and hands the new PC/SP/P to the core through single-cycle write strobes.
module interrupt_sequencer #(
  parameter logic [7:0]  STACK_PAGE   = 8'h01,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        brk_i,
  input  logic        rti_i,
  input  logic        irq_i,
  input  logic        nmi_i,
  input  logic [7:0]  status_i,
  input  logic [15:0] pc_i,
  input  logic [7:0]  sp_i,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  output logic [15:0] pc_o,
  output logic        pc_we_o,
  output logic [7:0]  sp_o,
  output logic        sp_we_o,
  output logic [7:0]  status_o,
  output logic        status_we_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [3:0] {
    StIdle, StPushPch, StPushPcl, StPushP, StVecLo, StVecHi,
    StPullP, StPullPcl, StPullPch, StRstLo, StRstHi, StFinish
  } state_e;

  typedef enum logic [1:0] {KindInt, KindBrk, KindRti, KindRst} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic        armed_q, nmi_pending_q, nmi_pending_d, nmi_prev_q;
  logic [15:0] pc_q, pc_d, vec_q, vec_d;
  logic [7:0]  sp_q, sp_d, p_q, p_d, lo_q, lo_d, hi_q, hi_d;
  logic [7:0]  sp_inc, sp_dec;
  logic        nmi_edge, nmi_clr, mem_done;

  assign nmi_edge = nmi_i & ~nmi_prev_q;
  assign mem_done = mem_req_o & mem_ready_i;
  assign sp_inc   = sp_q + 8'd1;
  assign sp_dec   = sp_q - 8'd1;

  // armed_q holds off the first reset-vector read for one cycle after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StRstLo;
      kind_q        <= KindRst;
      armed_q       <= 1'b0;
      nmi_pending_q <= 1'b0;
      nmi_prev_q    <= 1'b0;
      pc_q          <= '0;
      vec_q         <= '0;
      sp_q          <= '0;
      p_q           <= '0;
      lo_q          <= '0;
      hi_q          <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      armed_q       <= 1'b1;
      nmi_pending_q <= nmi_pending_d;
      nmi_prev_q    <= nmi_i;
      pc_q          <= pc_d;
      vec_q         <= vec_d;
      sp_q          <= sp_d;
      p_q           <= p_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    vec_d   = vec_q;
    sp_d    = sp_q;
    p_d     = p_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    nmi_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (nmi_pending_q) begin
          state_d = StPushPch;
          kind_d  = KindInt;
          vec_d   = NMI_VECTOR;
          nmi_clr = 1'b1;
        end else if (brk_i) begin
          state_d = StPushPch;
          kind_d  = KindBrk;
          vec_d   = IRQ_VECTOR;
        end else if (rti_i) begin
          state_d = StPullP;
          kind_d  = KindRti;
        end else if (irq_i && !status_i[2]) begin
          state_d = StPushPch;
          kind_d  = KindInt;
          vec_d   = IRQ_VECTOR;
        end
        if (state_d != StIdle) begin
          pc_d = pc_i;
          sp_d = sp_i;
          p_d  = status_i;
        end
      end
      StPushPch: if (mem_done) begin sp_d = sp_dec; state_d = StPushPcl; end
      StPushPcl: if (mem_done) begin sp_d = sp_dec; state_d = StPushP; end
      StPushP:   if (mem_done) begin sp_d = sp_dec; state_d = StVecLo; end
      StVecLo:   if (mem_done) begin lo_d = mem_data_i; state_d = StVecHi; end
      StVecHi:   if (mem_done) begin hi_d = mem_data_i; state_d = StFinish; end
      StPullP:   if (mem_done) begin sp_d = sp_inc; p_d = mem_data_i; state_d = StPullPcl; end
      StPullPcl: if (mem_done) begin sp_d = sp_inc; lo_d = mem_data_i; state_d = StPullPch; end
      StPullPch: if (mem_done) begin sp_d = sp_inc; hi_d = mem_data_i; state_d = StFinish; end
      StRstLo:   if (mem_done) begin lo_d = mem_data_i; state_d = StRstHi; end
      StRstHi:   if (mem_done) begin hi_d = mem_data_i; state_d = StFinish; end
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // A fresh edge in the accept cycle must survive the clear.
    nmi_pending_d = (nmi_pending_q & ~nmi_clr) | nmi_edge;
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    pc_o        = '0;
    pc_we_o     = 1'b0;
    sp_o        = '0;
    sp_we_o     = 1'b0;
    status_o    = '0;
    status_we_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state_q != StIdle);
    unique case (state_q)
      StPushPch, StPushPcl, StPushP: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {STACK_PAGE, sp_q};
        if (state_q == StPushPch)      mem_data_o = pc_q[15:8];
        else if (state_q == StPushPcl) mem_data_o = pc_q[7:0];
        else mem_data_o = {p_q[7:6], 1'b1, kind_q == KindBrk, p_q[3:0]};
      end
      StVecLo: begin
        mem_req_o  = 1'b1;
        mem_addr_o = vec_q;
      end
      StVecHi: begin
        mem_req_o  = 1'b1;
        mem_addr_o = vec_q + 16'd1;
      end
      StPullP, StPullPcl, StPullPch: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {STACK_PAGE, sp_inc};
      end
      StRstLo: begin
        mem_req_o  = armed_q;
        mem_addr_o = armed_q ? RESET_VECTOR : 16'h0000;
      end
      StRstHi: begin
        mem_req_o  = 1'b1;
        mem_addr_o = RESET_VECTOR + 16'd1;
      end
      StFinish: begin
        done_o      = 1'b1;
        pc_we_o     = 1'b1;
        status_we_o = 1'b1;
        pc_o        = {hi_q, lo_q};
        sp_we_o     = (kind_q != KindRst);
        sp_o        = (kind_q != KindRst) ? sp_q : 8'h00;
        case (kind_q)
          KindBrk: status_o = {p_q[7:5], 1'b1, p_q[3], 1'b1, p_q[1:0]};
          KindInt: status_o = {p_q[7:5], 1'b0, p_q[3], 1'b1, p_q[1:0]};
          KindRti: status_o = {p_q[7:6], 1'b1, 1'b0, p_q[3:0]};
          default: status_o = {status_i[7:3], 1'b1, status_i[1:0]};
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios plus randomized sequences checked against
// a transaction-level model of the expected stack/vector accesses and final register writes.
module tb_interrupt_sequencer;

  localparam int KBrk = 0, KIrq = 1, KNmi = 2, KPend = 3, KRti = 4, KRst = 5;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        brk_i = 1'b0, rti_i = 1'b0, irq_i = 1'b0, nmi_i = 1'b0;
  logic [7:0]  status_i = 8'h00;
  logic [15:0] pc_i = 16'h0000;
  logic [7:0]  sp_i = 8'h00;
  logic [7:0]  mem_data_i;
  logic        mem_ready_i = 1'b1;
  logic        mem_req_o, mem_we_o, pc_we_o, sp_we_o, status_we_o, busy_o, done_o;
  logic [15:0] mem_addr_o, pc_o;
  logic [7:0]  mem_data_o, sp_o, status_o;

  logic [7:0]  mem [0:65535];
  logic [24:0] log_q[$];
  logic [24:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;
  int          stall_cnt = 0;
  logic [25:0] held, cur;
  bit          stalled = 1'b0;

  interrupt_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .brk_i(brk_i), .rti_i(rti_i), .irq_i(irq_i), .nmi_i(nmi_i),
    .status_i(status_i), .pc_i(pc_i), .sp_i(sp_i), .mem_data_i(mem_data_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .pc_o(pc_o), .pc_we_o(pc_we_o),
    .sp_o(sp_o), .sp_we_o(sp_we_o), .status_o(status_o), .status_we_o(status_we_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  assign mem_data_i = mem[mem_addr_o];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ready: 0 = always ready, 1 = random, 2 = three wait cycles per access.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: mem_ready_i = 1'b1;
      1: mem_ready_i = 1'($urandom_range(0, 1));
      default: begin
        if (!mem_req_o) begin
          stall_cnt   = 0;
          mem_ready_i = 1'b0;
        end else begin
          mem_ready_i = (stall_cnt == 3);
          stall_cnt   = mem_ready_i ? 0 : stall_cnt + 1;
        end
      end
    endcase
  end

  // Memory responder, access logger and stall-stability monitor.
  always @(negedge clk) begin
    cur = {mem_req_o, mem_we_o, mem_addr_o, mem_data_o};
    if (rst_i) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", 32'(cur), 32'(held));
      stalled = mem_req_o && !mem_ready_i;
      held    = cur;
      if (mem_req_o && mem_ready_i) begin
        log_q.push_back({mem_we_o, mem_addr_o, mem_we_o ? mem_data_o : 8'h00});
        if (mem_we_o) mem[mem_addr_o] = mem_data_o;
      end
    end
  end

  task automatic run(input int kind, input logic [15:0] pc, input logic [7:0] sp,
                     input logic [7:0] p, input int lat, input bit nmi_too);
    logic [15:0] vec, e_pc;
    logic [7:0]  s, pp, pl, e_sp, e_st;
    bit          e_spwe, brk;
    int          cyc;
    exp_q.delete();
    log_q.delete();
    e_spwe = 1'b1;
    brk    = (kind == KBrk);
    s      = sp;
    if (kind == KRti) begin
      s  = s + 8'd1;
      pl = mem[{8'h01, s}];
      exp_q.push_back({1'b0, 8'h01, s, 8'h00});
      s = s + 8'd1;
      e_pc[7:0] = mem[{8'h01, s}];
      exp_q.push_back({1'b0, 8'h01, s, 8'h00});
      s = s + 8'd1;
      e_pc[15:8] = mem[{8'h01, s}];
      exp_q.push_back({1'b0, 8'h01, s, 8'h00});
      e_sp = s;
      e_st = (pl | 8'h20) & 8'hEF;
    end else if (kind == KRst) begin
      exp_q.push_back({1'b0, 16'hFFFC, 8'h00});
      exp_q.push_back({1'b0, 16'hFFFD, 8'h00});
      e_pc   = {mem[16'hFFFD], mem[16'hFFFC]};
      e_sp   = 8'h00;
      e_st   = p | 8'h04;
      e_spwe = 1'b0;
    end else begin
      vec = (kind == KNmi || kind == KPend) ? 16'hFFFA : 16'hFFFE;
      pp  = ((p | 8'h20) & 8'hEF) | (brk ? 8'h10 : 8'h00);
      exp_q.push_back({1'b1, 8'h01, s, pc[15:8]});
      s = s - 8'd1;
      exp_q.push_back({1'b1, 8'h01, s, pc[7:0]});
      s = s - 8'd1;
      exp_q.push_back({1'b1, 8'h01, s, pp});
      s = s - 8'd1;
      exp_q.push_back({1'b0, vec, 8'h00});
      exp_q.push_back({1'b0, vec + 16'd1, 8'h00});
      e_pc = {mem[vec + 16'd1], mem[vec]};
      e_sp = s;
      e_st = (p & 8'hEF) | 8'h04 | (brk ? 8'h10 : 8'h00);
    end
    pc_i = pc;
    sp_i = sp;
    status_i = p;
    case (kind)
      KBrk: brk_i = 1'b1;
      KRti: rti_i = 1'b1;
      KIrq: irq_i = 1'b1;
      KNmi: nmi_i = 1'b1;
      KRst: rst_i = 1'b0;
      default: ;
    endcase
    if (nmi_too) nmi_i = 1'b1;
    cyc = 0;
    while (!done_o && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        brk_i = 1'b0;
        rti_i = 1'b0;
        irq_i = 1'b0;
        nmi_i = 1'b0;
      end
      if (cyc == 2 && kind != KRst) begin
        pc_i = 16'($urandom);
        sp_i = 8'($urandom);
        status_i = 8'($urandom);
      end
    end
    check("done_seen", 32'(done_o), 32'd1);
    if (lat != 0) check("latency", cyc, lat);
    check("access_count", log_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < log_q.size()) check($sformatf("access%0d", i), 32'(log_q[i]), 32'(exp_q[i]));
    check("pc_o", {pc_we_o, pc_o}, {1'b1, e_pc});
    check("status_o", {status_we_o, status_o}, {1'b1, e_st});
    check("sp_we_o", 32'(sp_we_o), 32'(e_spwe));
    if (e_spwe) check("sp_o", 32'(sp_o), 32'(e_sp));
    @(posedge clk);
    #1;
    check("done_pulse", {done_o, busy_o}, 2'b00);
  endtask

  initial begin
    int kind, lat;
    logic [7:0] p;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {busy_o, mem_req_o, mem_we_o, done_o, pc_we_o, sp_we_o, status_we_o},
          7'b1000000);
    check("rst_addr_pc", {mem_addr_o, pc_o}, 32'h0);
    check("rst_data", {mem_data_o, sp_o, status_o}, 24'h0);

    run(KRst, 16'h0000, 8'h00, 8'h00, 3, 1'b0);
    run(KBrk, 16'hC003, 8'hFD, 8'h20, 6, 1'b0);
    check("brk_stack", {mem[16'h01FD], mem[16'h01FC], mem[16'h01FB]}, 24'hC00330);
    mem[16'h01FB] = 8'hC3;
    run(KRti, 16'h0000, 8'hFA, 8'h00, 4, 1'b0);

    irq_i = 1'b1;
    status_i = 8'h04;
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("irq_masked", 32'(busy_o), 32'd0);
    end
    check("irq_masked_mem", log_q.size(), 0);
    run(KIrq, 16'h4567, 8'hF0, 8'hA1, 6, 1'b1);
    run(KPend, 16'h89AB, 8'hE0, 8'h43, 6, 1'b0);

    run(KIrq, 16'h2468, 8'h01, 8'h80, 6, 1'b0);
    run(KRti, 16'h0000, 8'hFE, 8'h00, 4, 1'b0);

    for (int it = 0; it < 24; it++) begin
      ready_mode = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      if (kind == 3) kind = KRti;
      p = 8'($urandom);
      if (kind == KIrq) p[2] = 1'b0;
      lat = 0;
      if (ready_mode == 0) lat = (kind == KNmi) ? 7 : (kind == KRti) ? 4 : 6;
      run(kind, 16'($urandom), 8'($urandom), p, lat, 1'b0);
    end

    ready_mode = 2;
    run(KBrk, 16'h1357, 8'h80, 8'h00, 21, 1'b0);
    pc_i = 16'hBEEF;
    sp_i = 8'h40;
    status_i = 8'h00;
    brk_i = 1'b1;
    @(posedge clk);
    #1;
    brk_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_point", {mem_req_o, mem_we_o, mem_addr_o}, {2'b11, 16'h013F});
    rst_i = 1'b1;
    #1;
    check("abort_ctl", {busy_o, mem_req_o, pc_we_o, done_o}, 4'b1000);
    check("abort_partial", 32'(mem[16'h0140]), 32'hBE);
    ready_mode = 0;
    @(posedge clk);
    #1;
    run(KRst, 16'h0000, 8'h00, 8'h10, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
